// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW front end: bundle width, opcode constants
// used by the slot control circuits, and the fetch FSM state encoding.
package vliw_pkg;
   localparam int BUNDLE_W = 48;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [1:0] C0     = 2'b00;
   localparam logic [1:0] C2     = 2'b10;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_KILL = 2'd2
   } state_t;
endpackage

// File: rtl/vliw_bundle_split.sv
// Splits an IF/ID bundle into the fields consumed by the 32-bit and 16-bit slot
// control circuits; every output is zero when the bundle is not live.
module vliw_bundle_split
   import vliw_pkg::*;
(
   input  logic                valid,
   input  logic [BUNDLE_W-1:0] bundle,
   output logic [31:0]         instr32,
   output logic [15:0]         instr16,
   output logic [6:0]          opcode32,
   output logic [2:0]          funct3_32,
   output logic [6:0]          funct7_32,
   output logic [4:0]          rd32,
   output logic [4:0]          rs1_32,
   output logic [4:0]          rs2_32,
   output logic [1:0]          opcode16,
   output logic [3:0]          funct16
);
   assign instr32   = valid ? bundle[47:16] : '0;
   assign instr16   = valid ? bundle[15:0]  : '0;

   assign opcode32  = instr32[6:0];
   assign funct3_32 = instr32[14:12];
   assign funct7_32 = instr32[31:25];
   assign rd32      = instr32[11:7];
   assign rs1_32    = instr32[19:15];
   assign rs2_32    = instr32[24:20];
   assign opcode16  = instr16[1:0];
   assign funct16   = instr16[15:12];
endmodule

// File: rtl/vliw_fetch_decode.sv
// VLIW fetch/decode front end: PC, synchronous imem request, IF/ID register with
// a one-entry skid buffer for stalls, and redirect with wrong-path kill.
module vliw_fetch_decode
   import vliw_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter int              PC_STEP  = 6,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                redirect,
   input  logic [PC_W-1:0]     redirect_pc,
   output logic                imem_req,
   output logic [PC_W-1:0]     imem_addr,
   input  logic [BUNDLE_W-1:0] imem_rdata,
   output logic                id_valid,
   output logic [PC_W-1:0]     id_pc,
   output logic [31:0]         instr32,
   output logic [15:0]         instr16,
   output logic [6:0]          opcode32,
   output logic [2:0]          funct3_32,
   output logic [6:0]          funct7_32,
   output logic [4:0]          rd32,
   output logic [4:0]          rs1_32,
   output logic [4:0]          rs2_32,
   output logic [1:0]          opcode16,
   output logic [3:0]          funct16
);
   localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

   state_t              state, state_nxt;
   logic [PC_W-1:0]     pc_f, pc_f_nxt;
   logic                req;
   logic                inflight, inflight_nxt;
   logic [PC_W-1:0]     inflight_pc;
   logic                skid_valid, skid_valid_nxt, skid_load;
   logic [BUNDLE_W-1:0] skid_data;
   logic [PC_W-1:0]     skid_pc;
   logic                vld_p1, vld_p1_nxt, id_load, id_from_skid;
   logic [BUNDLE_W-1:0] bundle_p1;
   logic [PC_W-1:0]     pc_p1;

   always_comb begin
      state_nxt      = state;
      pc_f_nxt       = pc_f;
      req            = 1'b0;
      inflight_nxt   = 1'b0;
      skid_valid_nxt = skid_valid;
      skid_load      = 1'b0;
      vld_p1_nxt     = vld_p1;
      id_load        = 1'b0;
      id_from_skid   = 1'b0;
      // Redirect wins over stall; data returning this cycle is wrong-path.
      if (redirect) begin
         state_nxt      = S_KILL;
         pc_f_nxt       = redirect_pc;
         skid_valid_nxt = 1'b0;
         vld_p1_nxt     = 1'b0;
      end else begin
         case (state)
            S_BOOT: state_nxt = S_RUN;
            S_RUN: begin
               if (stall) begin
                  if (inflight) begin
                     skid_load      = 1'b1;
                     skid_valid_nxt = 1'b1;
                  end
               end else begin
                  req          = 1'b1;
                  pc_f_nxt     = pc_f + STEP;
                  inflight_nxt = 1'b1;
                  if (skid_valid) begin
                     id_load        = 1'b1;
                     id_from_skid   = 1'b1;
                     vld_p1_nxt     = 1'b1;
                     skid_valid_nxt = 1'b0;
                  end else if (inflight) begin
                     id_load    = 1'b1;
                     vld_p1_nxt = 1'b1;
                  end else begin
                     vld_p1_nxt = 1'b0;
                  end
               end
            end
            S_KILL: begin
               if (!stall) begin
                  req          = 1'b1;
                  pc_f_nxt     = pc_f + STEP;
                  inflight_nxt = 1'b1;
                  vld_p1_nxt   = 1'b0;
                  state_nxt    = S_RUN;
               end
            end
            default: state_nxt = S_BOOT;
         endcase
      end
   end

   assign imem_req  = req & ~reset;
   assign imem_addr = pc_f;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_BOOT;
         pc_f       <= RESET_PC;
         inflight   <= 1'b0;
         skid_valid <= 1'b0;
         vld_p1     <= 1'b0;
         bundle_p1  <= '0;
         pc_p1      <= '0;
      end else begin
         state      <= state_nxt;
         pc_f       <= pc_f_nxt;
         inflight   <= inflight_nxt;
         skid_valid <= skid_valid_nxt;
         vld_p1     <= vld_p1_nxt;
         // IF/ID stage boundary
         if (id_load) begin
            bundle_p1 <= id_from_skid ? skid_data : imem_rdata;
            pc_p1     <= id_from_skid ? skid_pc : inflight_pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (req) inflight_pc <= pc_f;
      if (skid_load) begin
         skid_data <= imem_rdata;
         skid_pc   <= inflight_pc;
      end
   end

   assign id_valid = vld_p1;
   assign id_pc    = pc_p1;

   vliw_bundle_split u_split (
      .valid     (vld_p1),
      .bundle    (bundle_p1),
      .instr32   (instr32),
      .instr16   (instr16),
      .opcode32  (opcode32),
      .funct3_32 (funct3_32),
      .funct7_32 (funct7_32),
      .rd32      (rd32),
      .rs1_32    (rs1_32),
      .rs2_32    (rs2_32),
      .opcode16  (opcode16),
      .funct16   (funct16)
   );
endmodule

// File: tb/tb_vliw_fetch_decode.sv
// Directed bench for vliw_fetch_decode: free run, field split, stall/skid,
// redirect, redirect under stall with PC wrap, and reset mid-operation.
module tb_vliw_fetch_decode;
   logic        clk = 1'b0;
   logic        reset, stall, redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [47:0] imem_rdata = '0;
   logic        id_valid;
   logic [31:0] id_pc, instr32;
   logic [15:0] instr16;
   logic [6:0]  opcode32, funct7_32;
   logic [2:0]  funct3_32;
   logic [4:0]  rd32, rs1_32, rs2_32;
   logic [1:0]  opcode16;
   logic [3:0]  funct16;

   int checks = 0;
   int errors = 0;

   vliw_fetch_decode #(.PC_W(32), .PC_STEP(6), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .id_valid(id_valid), .id_pc(id_pc),
      .instr32(instr32), .instr16(instr16), .opcode32(opcode32),
      .funct3_32(funct3_32), .funct7_32(funct7_32), .rd32(rd32),
      .rs1_32(rs1_32), .rs2_32(rs2_32), .opcode16(opcode16), .funct16(funct16)
   );

   always #5 clk = ~clk;

   // Tagged instruction memory; address 0x30 holds a real addi bundle.
   function automatic logic [47:0] mem_word(input logic [31:0] a);
      if (a == 32'h30) return 48'h00A30093_4581;
      return {a ^ 32'h5A00_0000, a[15:0] ^ 16'hC3C3};
   endfunction

   always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bundle(input string tag, input logic [31:0] pc);
      logic [47:0] w;
      logic [31:0] i32;
      logic [15:0] i16;
      w   = mem_word(pc);
      i32 = w[47:16];
      i16 = w[15:0];
      chk({tag, ".valid"}, 64'(id_valid), 64'd1);
      chk({tag, ".pc"}, 64'(id_pc), 64'(pc));
      chk({tag, ".instr32"}, 64'(instr32), 64'(i32));
      chk({tag, ".instr16"}, 64'(instr16), 64'(i16));
      chk({tag, ".opcode32"}, 64'(opcode32), 64'(i32[6:0]));
      chk({tag, ".rd32"}, 64'(rd32), 64'(i32[11:7]));
      chk({tag, ".funct7"}, 64'(funct7_32), 64'(i32[31:25]));
      chk({tag, ".funct16"}, 64'(funct16), 64'(i16[15:12]));
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, ".valid"}, 64'(id_valid), 64'd0);
      chk({tag, ".fields"}, {instr32, instr16, opcode16, funct16, 10'd0}, 64'd0);
      chk({tag, ".op"}, {opcode32, funct3_32, funct7_32, rd32, rs1_32, rs2_32}, 64'd0);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      tick(); tick();
      chk_empty("reset");
      chk("reset.req", 64'(imem_req), 64'd0);
      chk("reset.pc", 64'(id_pc), 64'd0);

      // Boot cycle, then sequential fetch from 0
      reset = 1'b0; #1;
      chk("boot.req", 64'(imem_req), 64'd0);
      tick();
      chk("run.req0", 64'(imem_req), 64'd1);
      chk("run.addr0", 64'(imem_addr), 64'd0);
      chk_empty("run.c1");
      tick();
      chk("run.addr1", 64'(imem_addr), 64'd6);
      chk_empty("run.c2");
      for (int k = 0; k < 10; k++) begin
         tick();
         chk_bundle("seq", 32'(6 * k));
         chk("seq.addr", 64'(imem_addr), 64'(6 * (k + 2)));
      end
      chk("seq.frozen_pc", 64'(id_pc), 64'd54);

      // Field split of the addi bundle at 0x30
      stall = 1'b0;

      // Stall 3 cycles with the fetch of 60 in flight
      stall = 1'b1; #1;
      chk("stall.req", 64'(imem_req), 64'd0);
      tick(); chk_bundle("stall1", 32'd54); chk("stall1.req", 64'(imem_req), 64'd0);
      tick(); chk_bundle("stall2", 32'd54);
      tick(); chk_bundle("stall3", 32'd54);
      stall = 1'b0; #1;
      chk("release.req", 64'(imem_req), 64'd1);
      chk("release.addr", 64'(imem_addr), 64'd66);
      tick(); chk_bundle("skid", 32'd60); chk("skid.addr", 64'(imem_addr), 64'd72);
      tick(); chk_bundle("after_skid", 32'd66);
      tick(); chk_bundle("after_skid2", 32'd72);

      // Redirect to 0x120
      redirect = 1'b1; redirect_pc = 32'h120; #1;
      chk("redir.req", 64'(imem_req), 64'd0);
      tick(); redirect = 1'b0; #1;
      chk_empty("redir.t1");
      chk("redir.t1.req", 64'(imem_req), 64'd1);
      chk("redir.t1.addr", 64'(imem_addr), 64'h120);
      tick(); chk_empty("redir.t2");
      tick(); chk_bundle("redir.t3", 32'h120);
      tick(); chk_bundle("redir.t4", 32'h126);

      // Redirect with stall, target near the top of the address space
      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
      chk("rs.req", 64'(imem_req), 64'd0);
      tick(); redirect = 1'b0; #1;
      chk_empty("rs.u1");
      chk("rs.u1.req", 64'(imem_req), 64'd0);
      tick(); stall = 1'b0; #1;
      chk_empty("rs.u2");
      chk("rs.u2.req", 64'(imem_req), 64'd1);
      chk("rs.u2.addr", 64'(imem_addr), 64'hFFFF_FFFC);
      tick(); chk_empty("rs.u3"); chk("wrap.addr", 64'(imem_addr), 64'h2);
      tick(); chk_bundle("rs.u4", 32'hFFFF_FFFC);
      tick(); chk_bundle("wrap", 32'h2);

      // Fill the skid buffer, then reset on top of it
      stall = 1'b1;
      tick(); chk_bundle("pre_reset", 32'h2);
      reset = 1'b1;
      tick();
      chk_empty("midreset");
      chk("midreset.pc", 64'(id_pc), 64'd0);
      chk("midreset.req", 64'(imem_req), 64'd0);
      reset = 1'b0; stall = 1'b0; #1;
      chk("reboot.req", 64'(imem_req), 64'd0);
      tick();
      chk("refetch.req", 64'(imem_req), 64'd1);
      chk("refetch.addr", 64'(imem_addr), 64'd0);
      tick(); chk_empty("refetch.c2");
      tick(); chk_bundle("refetch0", 32'd0);
      tick(); chk_bundle("refetch1", 32'd6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Decoded view of the addi bundle whenever it is live in IF/ID
   always @(negedge clk) begin
      if (id_valid && id_pc == 32'h30) begin
         chk("addi.opcode32", 64'(opcode32), 64'h13);
         chk("addi.funct3", 64'(funct3_32), 64'd0);
         chk("addi.rd32", 64'(rd32), 64'd1);
         chk("addi.rs1", 64'(rs1_32), 64'd6);
         chk("addi.rs2", 64'(rs2_32), 64'd10);
         chk("addi.opcode16", 64'(opcode16), 64'b01);
         chk("addi.funct16", 64'(funct16), 64'h4);
      end
   end
endmodule
